// File: rtl/ram_stream_pkg.sv
// Shared types and helpers for the RAM byte-stream loader.
// RAM_STREAM_CHECKSUM_EN adds the DUMP_SUM state to the state encoding.
package ram_stream_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_BYTE,
      LOAD_WRITE,
      DUMP_READ,
      DUMP_WAIT,
      DUMP_SEND,
`ifdef RAM_STREAM_CHECKSUM_EN
      DUMP_SUM,
`endif
      FINISH
   } state_t;

   function automatic int bytes_per_word(input int width);
      return (width + BYTE_W - 1) / BYTE_W;
   endfunction

endpackage

// File: rtl/ram_stream_loader_shifter.sv
// word_byte_shifter: packs rx bytes little-endian into a word on load and
// unpacks a captured RAM word into bytes (LSB first) on dump.
module word_byte_shifter
   import ram_stream_pkg::*;
#(
   parameter int WIDTH = 12
) (
   input  logic              clk,
   input  logic              rstN,
   input  logic              clear,
   input  logic              shift_in,
   input  logic [BYTE_W-1:0] byte_in,
   input  logic              capture,
   input  logic [WIDTH-1:0]  word_in,
   input  logic              shift_out,
   output logic [WIDTH-1:0]  word_out,
   output logic [BYTE_W-1:0] byte_out,
   output logic              last
);

   localparam int BYTES = bytes_per_word(WIDTH);
   localparam int TOT_W = BYTES * BYTE_W;
   localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

   logic [TOT_W-1:0]        sh;
   logic [CNT_W-1:0]        cnt;
   logic [TOT_W+BYTE_W-1:0] pushed;
   logic [CNT_W-1:0]        cnt_adv;

   // New bytes enter at the top, so after BYTES shifts byte 0 sits in bits [7:0].
   assign pushed  = {byte_in, sh};
   assign last    = (cnt == CNT_W'(BYTES - 1));
   assign cnt_adv = last ? '0 : cnt + CNT_W'(1);

   always_ff @(posedge clk) begin
      if (!rstN) begin
         sh  <= '0;
         cnt <= '0;
      end else if (clear) begin
         sh  <= '0;
         cnt <= '0;
      end else if (capture) begin
         sh  <= TOT_W'(word_in);
         cnt <= '0;
      end else if (shift_in) begin
         sh  <= pushed[TOT_W+BYTE_W-1:BYTE_W];
         cnt <= cnt_adv;
      end else if (shift_out) begin
         sh  <= sh >> BYTE_W;
         cnt <= cnt_adv;
      end
   end

   assign word_out = sh[WIDTH-1:0];
   assign byte_out = sh[BYTE_W-1:0];

endmodule

// File: rtl/ram_stream_loader.sv
// Byte-stream front end that loads/dumps a WIDTH x DEPTH registered-read RAM.
// Define RAM_STREAM_CHECKSUM_EN to append a mod-256 checksum byte to dumps.
module ram_stream_loader
   import ram_stream_pkg::*;
#(
   parameter int WIDTH      = 12,
   parameter int DEPTH      = 256,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rstN,
   input  logic                  start_load,
   input  logic                  start_dump,
   input  logic [ADDR_WIDTH:0]   word_count,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   output logic                  rx_ready,
   output logic [7:0]            tx_data,
   output logic                  tx_valid,
   input  logic                  tx_ready,
   output logic                  mem_wrEn,
   output logic [WIDTH-1:0]      mem_dataIn,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [WIDTH-1:0]      mem_dataOut,
   output logic                  busy,
   output logic                  done
);

   localparam int CW = ADDR_WIDTH + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   state_t          state, state_n;
   logic [CW-1:0]   idx, idx_n, total, total_n, clamped, idx_inc;
   logic            clear, shift_in, capture, shift_out, last;
   logic [WIDTH-1:0] word_out;
   logic [7:0]      byte_out;
`ifdef RAM_STREAM_CHECKSUM_EN
   logic [7:0]      sum, sum_n;
`endif

   word_byte_shifter #(.WIDTH(WIDTH)) u_shifter (
      .clk       (clk),
      .rstN      (rstN),
      .clear     (clear),
      .shift_in  (shift_in),
      .byte_in   (rx_data),
      .capture   (capture),
      .word_in   (mem_dataOut),
      .shift_out (shift_out),
      .word_out  (word_out),
      .byte_out  (byte_out),
      .last      (last)
   );

   assign clamped = (word_count > DEPTH_C) ? DEPTH_C : word_count;
   assign idx_inc = idx + CW'(1);

   always_ff @(posedge clk) begin
      if (!rstN) begin
         state <= IDLE;
         idx   <= '0;
         total <= '0;
`ifdef RAM_STREAM_CHECKSUM_EN
         sum   <= '0;
`endif
      end else begin
         state <= state_n;
         idx   <= idx_n;
         total <= total_n;
`ifdef RAM_STREAM_CHECKSUM_EN
         sum   <= sum_n;
`endif
      end
   end

   always_comb begin
      state_n    = state;
      idx_n      = idx;
      total_n    = total;
`ifdef RAM_STREAM_CHECKSUM_EN
      sum_n      = sum;
`endif
      clear      = 1'b0;
      shift_in   = 1'b0;
      capture    = 1'b0;
      shift_out  = 1'b0;
      rx_ready   = 1'b0;
      tx_valid   = 1'b0;
      tx_data    = '0;
      mem_wrEn   = 1'b0;
      mem_dataIn = '0;
      mem_addr   = '0;
      busy       = (state != IDLE);
      done       = 1'b0;

      case (state)
         IDLE: begin
            // Load has priority when both starts arrive together.
            if (start_load || start_dump) begin
               clear   = 1'b1;
               idx_n   = '0;
               total_n = clamped;
`ifdef RAM_STREAM_CHECKSUM_EN
               sum_n   = '0;
`endif
               if (clamped == '0)   state_n = FINISH;
               else if (start_load) state_n = LOAD_BYTE;
               else                 state_n = DUMP_READ;
            end
         end
         LOAD_BYTE: begin
            rx_ready = 1'b1;
            if (rx_valid) begin
               shift_in = 1'b1;
               if (last) state_n = LOAD_WRITE;
            end
         end
         LOAD_WRITE: begin
            mem_wrEn   = 1'b1;
            mem_addr   = idx[ADDR_WIDTH-1:0];
            mem_dataIn = word_out;
            idx_n      = idx_inc;
            state_n    = (idx_inc == total) ? FINISH : LOAD_BYTE;
         end
         DUMP_READ: begin
            mem_addr = idx[ADDR_WIDTH-1:0];
            state_n  = DUMP_WAIT;
         end
         DUMP_WAIT: begin
            capture = 1'b1;
            state_n = DUMP_SEND;
         end
         DUMP_SEND: begin
            tx_valid = 1'b1;
            tx_data  = byte_out;
            if (tx_ready) begin
               shift_out = 1'b1;
`ifdef RAM_STREAM_CHECKSUM_EN
               sum_n     = sum + byte_out;
`endif
               if (last) begin
                  idx_n = idx_inc;
                  if (idx_inc != total) state_n = DUMP_READ;
`ifdef RAM_STREAM_CHECKSUM_EN
                  else                  state_n = DUMP_SUM;
`else
                  else                  state_n = FINISH;
`endif
               end
            end
         end
`ifdef RAM_STREAM_CHECKSUM_EN
         DUMP_SUM: begin
            tx_valid = 1'b1;
            tx_data  = sum;
            if (tx_ready) state_n = FINISH;
         end
`endif
         FINISH: begin
            // One spare cycle lets the RAM commit the last write before any read.
            done    = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_ram_stream_loader.sv
// Scoreboard bench for ram_stream_loader: randomized load/dump traffic against
// a word-level reference memory; a negedge monitor checks writes, tx bytes and done.
module tb_ram_stream_loader;

   localparam int WIDTH = 12;
   localparam int DEPTH = 256;
   localparam int AW    = 8;
   localparam int NB    = (WIDTH + 7) / 8;
   localparam int MASK  = (1 << WIDTH) - 1;

   logic           clk = 1'b0;
   logic           rstN;
   logic           start_load, start_dump;
   logic [AW:0]    word_count;
   logic [7:0]     rx_data;
   logic           rx_valid, rx_ready;
   logic [7:0]     tx_data;
   logic           tx_valid, tx_ready;
   logic           mem_wrEn;
   logic [WIDTH-1:0] mem_dataIn, mem_dataOut;
   logic [AW-1:0]  mem_addr;
   logic           busy, done;

   ram_stream_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .rstN(rstN), .start_load(start_load), .start_dump(start_dump),
      .word_count(word_count), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rx_ready), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .mem_wrEn(mem_wrEn), .mem_dataIn(mem_dataIn),
      .mem_addr(mem_addr), .mem_dataOut(mem_dataOut), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Registered-read RAM the loader drives.
   logic [WIDTH-1:0] ram [DEPTH];
   always @(posedge clk) begin
      if (mem_wrEn) ram[mem_addr] <= mem_dataIn;
      mem_dataOut <= ram[mem_addr];
   end

   int checks = 0;
   int errors = 0;
   int ref_mem [DEPTH];
   int exp_addr [$];
   int exp_data [$];
   int exp_tx [$];
   int exp_done = 0;
   int tx_seen = 0;
   int hold = 0;
   bit mon_en = 1'b0;
   logic [7:0] load_bytes [$];

   // Sink: random back-pressure, plus forced stalls on request.
   initial begin
      tx_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (hold > 0) begin
            tx_ready = 1'b0;
            hold--;
         end else begin
            tx_ready = ($urandom_range(0, 3) != 0);
         end
      end
   end

   // Monitor: pops the scoreboard whenever the DUT presents an output event.
   initial begin
      bit         stalled = 1'b0;
      logic [7:0] held = '0;
      int         a, d, e;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (mem_wrEn) begin
               checks++;
               if (exp_addr.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_write addr=%0d data=%h", mem_addr, mem_dataIn);
               end else begin
                  a = exp_addr.pop_front();
                  d = exp_data.pop_front();
                  if (int'(mem_addr) != a || int'(mem_dataIn) != d) begin
                     errors++;
                     $display("FAIL write got addr=%0d data=%h want addr=%0d data=%h",
                              mem_addr, mem_dataIn, a, d);
                  end
               end
            end
            if (tx_valid && exp_tx.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_tx_valid data=%h", tx_data);
            end else if (tx_valid && tx_ready) begin
               checks++;
               e = exp_tx.pop_front();
               tx_seen++;
               if (int'(tx_data) != e) begin
                  errors++;
                  $display("FAIL tx_byte got=%h want=%h", tx_data, e[7:0]);
               end
            end
            if (stalled) begin
               checks++;
               if (!tx_valid || tx_data != held) begin
                  errors++;
                  $display("FAIL tx_hold got valid=%0b data=%h want valid=1 data=%h",
                           tx_valid, tx_data, held);
               end
            end
            stalled = tx_valid && !tx_ready;
            held    = tx_data;
            if (done) begin
               checks++;
               if (exp_done == 0) begin
                  errors++;
                  $display("FAIL unexpected_done got=1 want=0");
               end else begin
                  exp_done--;
               end
            end
         end
      end
   end

   function automatic int clamp(input int c);
      return (c > DEPTH) ? DEPTH : c;
   endfunction

   task automatic check_idle_outputs(input string name);
      checks++;
      if ({rx_ready, tx_valid, tx_data, mem_wrEn, mem_dataIn, mem_addr, busy, done} != '0) begin
         errors++;
         $display("FAIL %s got rx_ready=%0b tx_valid=%0b tx_data=%h wrEn=%0b dataIn=%h addr=%0d busy=%0b done=%0b want all 0",
                  name, rx_ready, tx_valid, tx_data, mem_wrEn, mem_dataIn, mem_addr, busy, done);
      end
   endtask

   task automatic start_op(input bit ld, input bit dp, input int cnt);
      word_count = (AW+1)'(cnt);
      start_load = ld;
      start_dump = dp;
      @(posedge clk); #1;
      start_load = 1'b0;
      start_dump = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap, input bit mid_word);
      bit ok = 1'b0;
      for (int g = 0; g < gap; g++) begin
         @(negedge clk);
         if (mid_word) begin
            checks++;
            if (!rx_ready) begin
               errors++;
               $display("FAIL rx_ready_gap got=0 want=1");
            end
         end
         @(posedge clk); #1;
      end
      rx_valid = 1'b1;
      rx_data  = b;
      for (int n = 0; n < 200 && !ok; n++) begin
         @(negedge clk);
         ok = rx_ready;
         @(posedge clk); #1;
      end
      rx_valid = 1'b0;
      if (!ok) begin
         errors++;
         $display("FAIL rx_accept_timeout got=0 want=1");
      end
   endtask

   task automatic wait_done(input string name);
      for (int n = 0; n < 20000 && exp_done > 0; n++) @(negedge clk);
      checks++;
      if (exp_done > 0) begin
         errors++;
         exp_done = 0;
         $display("FAIL %s done_timeout got=0 want=1", name);
      end
      @(posedge clk); #1;
   endtask

   // abort_at >= 0: reset the DUT after that many bytes have been accepted.
   task automatic do_load(input int cnt, input bit both, input bit inject, input int abort_at);
      int n = clamp(cnt);
      int nbytes = (abort_at >= 0) ? abort_at : n * NB;
      logic [7:0] b [$];
      logic [7:0] bt;
      int w;
      for (int i = 0; i < n; i++) begin
         w = 0;
         for (int k = 0; k < NB; k++) begin
            bt = (load_bytes.size() > 0) ? load_bytes.pop_front() : 8'($urandom);
            b.push_back(bt);
            w = w | (int'(bt) << (8 * k));
         end
         w = w & MASK;
         if ((i + 1) * NB <= nbytes) begin
            exp_addr.push_back(i);
            exp_data.push_back(w);
            ref_mem[i] = w;
         end
      end
      if (abort_at < 0) exp_done++;
      start_op(1'b1, both, cnt);
      for (int j = 0; j < nbytes; j++) begin
         send_byte(b[j], $urandom_range(0, 2), (j % NB) != 0);
         if (inject && j == 0) start_op(1'b0, 1'b1, 3);
      end
      if (abort_at >= 0) begin
         rstN = 1'b0;
         @(posedge clk);
         @(negedge clk);
         check_idle_outputs("reset_mid_load");
         @(posedge clk); #1;
         rstN = 1'b1;
      end else begin
         wait_done("load");
      end
   endtask

   task automatic do_dump(input int cnt, input int hold_after);
      int n = clamp(cnt);
      int sum = 0;
      int bt;
      int base;
      for (int i = 0; i < n; i++) begin
         for (int k = 0; k < NB; k++) begin
            bt = (ref_mem[i] >> (8 * k)) & 8'hFF;
            exp_tx.push_back(bt);
            sum += bt;
         end
      end
`ifdef RAM_STREAM_CHECKSUM_EN
      exp_tx.push_back(sum & 8'hFF);
`endif
      exp_done++;
      base = tx_seen;
      start_op(1'b0, 1'b1, cnt);
      if (hold_after > 0) begin
         for (int t = 0; t < 2000 && tx_seen < base + hold_after; t++) @(negedge clk);
         hold = 5;
      end
      wait_done("dump");
   endtask

   task automatic do_zero(input bit ld);
      exp_done++;
      start_op(ld, !ld, 0);
      @(negedge clk);
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL zero_count_done got=%0b want=1", done);
      end
      @(posedge clk); #1;
      @(negedge clk);
      check_idle_outputs("zero_count_idle");
      @(posedge clk); #1;
   endtask

   initial begin
      #900000;
      $display("FAIL global_timeout got=running want=finished");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1);
   end

   initial begin
      rstN       = 1'b0;
      start_load = 1'b0;
      start_dump = 1'b0;
      word_count = '0;
      rx_data    = '0;
      rx_valid   = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_idle_outputs("reset_state");
      @(posedge clk); #1;
      rstN   = 1'b1;
      mon_en = 1'b1;
      @(posedge clk); #1;

      // Fixed load and dump of three words.
      load_bytes = '{8'h34, 8'h12, 8'hCD, 8'h0B, 8'hFF, 8'hFF};
      do_load(3, 1'b0, 1'b0, -1);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (int'(ram[i]) != ref_mem[i]) begin
            errors++;
            $display("FAIL ram_word%0d got=%h want=%h", i, ram[i], ref_mem[i]);
         end
      end
      do_dump(3, 3);

      do_zero(1'b1);
      do_zero(1'b0);

      // Both starts together: load executes.
      do_load(2, 1'b1, 1'b0, -1);
      // start_dump during a load must be ignored.
      do_load(2, 1'b0, 1'b1, -1);
      do_dump(2, 0);

      // Over-range count clamps to DEPTH.
      do_load(300, 1'b0, 1'b0, -1);
      do_dump(300, 7);

      // Reset after the first byte of word 1.
      do_load(3, 1'b0, 1'b0, NB + 1);
      do_dump(2, 0);

      checks++;
      if (exp_addr.size() != 0 || exp_tx.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got writes=%0d tx=%0d want 0 0",
                  exp_addr.size(), exp_tx.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
